mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Clocked front-end for the MEM stage of the pipelined datapath, placed between the EX/MEM pipeline register and the data memory. It converts level-held load/store requests from EX/MEM into clean, registered read/write strobes with a guaranteed rising edge per access, which the edge-triggered data memory requires. It holds the pipeline with `stall` for the duration of each access. It registers load data for the MEM/WB register and flags out-of-range or conflicting requests.

## Interface
- `ACCESS_CYCLES`, default 1: cycles a strobe is held high per access; legal range 1–15.
- `ADDR_W`, default 10: word-index width of the data memory; depth = 2^ADDR_W words.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_read`  in  1  load request from EX/MEM; held while `stall`=1.
- `req_write`  in  1  store request from EX/MEM; held while `stall`=1.
- `req_addr`  in  32  word index, not byte address.
- `req_wdata`  in  32  store data.
- `mem_address`  out  32  registered address to memory.
- `mem_wdata`  out  32  registered write data to memory.
- `mem_read`  out  1  registered read strobe.
- `mem_write`  out  1  registered write strobe.
- `mem_rdata`  in  32  memory read data; valid while `mem_read` is high.
- `rdata`  out  32  captured load data to MEM/WB.
- `rdata_valid`  out  1  one-cycle pulse marking completion of a load.
- `stall`  out  1  hold for PC, IF/ID, ID/EX and EX/MEM; combinational.
- `err`  out  1  one-cycle pulse on an illegal request.

## Operation
- States: IDLE, ACCESS, RELEASE.
- **IDLE**
  - Request = `req_read` | `req_write`.
  - In-range request (`req_addr[31:ADDR_W]`==0): latch `req_addr`, `req_wdata` and op into `mem_address`/`mem_wdata`, set the selected strobe, load the counter with `ACCESS_CYCLES`-1, go to ACCESS.
  - Out-of-range request: no strobe, set `err_pending`, go to RELEASE.
- **Simultaneous read and write:** perform the write only, no read strobe, `err` pulses in RELEASE, `rdata` unchanged.
- **ACCESS**
  - Strobe held high; counter decrements each cycle.
  - When counter==0: on a read, capture `mem_rdata` into `rdata`; drop both strobes; go to RELEASE.
- **RELEASE**
  - Strobes low; `rdata_valid`=1 if op was an in-range read; `err`=1 if `err_pending`.
  - For an out-of-range read, `rdata` is cleared to 0.
  - Always go to IDLE.
- **Stall:** `stall` = (IDLE & request) | ACCESS. It is 0 in RELEASE, so EX/MEM advances at the end of RELEASE.
- **Back-to-back accesses:** the strobe is low in RELEASE and for at least one IDLE cycle. Every access therefore sees a fresh rising edge, including repeated accesses to the same address.
- **Reset:** all outputs are 0 on the first edge with `rst`=1, state goes to IDLE, counter is cleared. An in-flight access is abandoned. A write whose strobe was already high may have committed; this is accepted.
- **Address masking:** upper address bits are never forwarded; `mem_address` = {zeros, `req_addr[ADDR_W-1:0]`}.

## Timing
- Request first seen in cycle t (IDLE) → strobe high in cycles t+1 … t+`ACCESS_CYCLES`.
- RELEASE occurs at cycle t+`ACCESS_CYCLES`+1; `rdata`/`rdata_valid` are valid in that cycle.
- Stall length = `ACCESS_CYCLES`+1 cycles per in-range access, and 1 cycle for an out-of-range access.
- Minimum spacing between strobe rising edges = `ACCESS_CYCLES`+2 cycles.
- All outputs except `stall` are registered. `stall` depends only on state and the request inputs, with no path from `mem_rdata`.

## Structure
- `mem_stage_pkg`
  - state enum (IDLE/ACCESS/RELEASE);
  - op encoding (NONE/LOAD/STORE);
  - 4-bit counter width constant.
- Sub-module `mem_access_timer`: loadable down-counter with a `zero` flag, reused by other multi-cycle units.
- Controller FSM, datapath latches and error logic live in `mem_stage_ctrl`.

## Test plan
- **Load, ACCESS_CYCLES=1:** read addr 1003, memory returns 15 → stall high 2 cycles, `mem_read` high 1 cycle, `rdata`=15 with `rdata_valid` pulse in cycle 3.
- **Store then load, same address:** write 77 to addr 5, then read addr 5 → two distinct `mem_write`/`mem_read` rising edges, `rdata`=77.
- **Back-to-back loads, ACCESS_CYCLES=3:** reads of addr 1000 then 1000 → each strobe high 3 cycles, low ≥2 cycles between them, `rdata`=10 twice.
- **Out of range:** `req_addr`=0x400 read → no strobe, stall 1 cycle, `err` pulse, `rdata`=0, `rdata_valid`=0.
- **Conflicting request:** `req_read`=`req_write`=1, addr 7, wdata 0xAA → write only, `err` pulse, `rdata` unchanged.
- **Reset mid-access:** `rst` asserted during ACCESS with ACCESS_CYCLES=4 → next cycle all outputs 0, state IDLE; a following read of addr 0 returns 9 normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage memory front-end.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

endpackage

// File: rtl/mem_access_timer.sv
// Loadable down-counter with a zero flag for multi-cycle unit sequencing.
module mem_access_timer
  import mem_stage_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns level-held load/store requests into registered,
// edge-clean memory strobes, stalls the pipeline and flags illegal requests.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned ADDR_W        = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_read,
  input  logic              i_req_write,
  input  logic [DATA_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic [DATA_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_valid,
  output logic              o_stall,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

  state_e            r_state, w_state_nxt;
  op_e               r_op, w_op_nxt;
  logic              r_err_pending, w_err_pending_nxt;
  logic [DATA_W-1:0] w_mem_address_nxt, w_mem_wdata_nxt, w_rdata_nxt;
  logic              w_mem_read_nxt, w_mem_write_nxt, w_rdata_valid_nxt, w_err_nxt;
  logic              w_req, w_in_range, w_conflict;
  logic              w_tmr_load, w_tmr_dec, w_tmr_zero;

  assign w_req      = i_req_read | i_req_write;
  assign w_in_range = (i_req_addr[DATA_W-1:ADDR_W] == '0);
  assign w_conflict = i_req_read & i_req_write;

  mem_access_timer #(.W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_tmr_dec),
    .o_zero_c   (w_tmr_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_req) w_state_nxt = w_in_range ? ST_ACCESS : ST_RELEASE;
      ST_ACCESS:  if (w_tmr_zero) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Stall plus next values of the registered datapath; a conflict resolves to a store.
  always_comb begin
    o_stall           = 1'b0;
    w_op_nxt          = r_op;
    w_err_pending_nxt = r_err_pending;
    w_mem_address_nxt = o_mem_address;
    w_mem_wdata_nxt   = o_mem_wdata;
    w_mem_read_nxt    = o_mem_read;
    w_mem_write_nxt   = o_mem_write;
    w_rdata_nxt       = o_rdata;
    w_rdata_valid_nxt = 1'b0;
    w_err_nxt         = 1'b0;
    w_tmr_load        = 1'b0;
    w_tmr_dec         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_stall = w_req;
        if (w_req) begin
          w_op_nxt          = i_req_write ? OP_STORE : OP_LOAD;
          w_err_pending_nxt = w_conflict | ~w_in_range;
          if (w_in_range) begin
            w_mem_address_nxt = DATA_W'(i_req_addr[ADDR_W-1:0]);
            w_mem_wdata_nxt   = i_req_wdata;
            w_mem_write_nxt   = i_req_write;
            w_mem_read_nxt    = ~i_req_write;
            w_tmr_load        = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
            if (!i_req_write) w_rdata_nxt = '0;
          end
        end
      end
      ST_ACCESS: begin
        o_stall = 1'b1;
        if (w_tmr_zero) begin
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_err_nxt       = r_err_pending;
          if (r_op == OP_LOAD) begin
            w_rdata_nxt       = i_mem_rdata;
            w_rdata_valid_nxt = 1'b1;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_RELEASE: begin
        w_op_nxt          = OP_NONE;
        w_err_pending_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op          <= OP_NONE;
      r_err_pending <= 1'b0;
      o_mem_address <= '0;
      o_mem_wdata   <= '0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      r_op          <= w_op_nxt;
      r_err_pending <= w_err_pending_nxt;
      o_mem_address <= w_mem_address_nxt;
      o_mem_wdata   <= w_mem_wdata_nxt;
      o_mem_read    <= w_mem_read_nxt;
      o_mem_write   <= w_mem_write_nxt;
      o_rdata       <= w_rdata_nxt;
      o_rdata_valid <= w_rdata_valid_nxt;
      o_err         <= w_err_nxt;
    end
  end

endmodule
